// File: rtl/mul_array_ctrl_pkg.sv
// mul_array_ctrl_pkg
//   Shared definitions for the multiplier array sequencing controller:
//   FSM state encoding, array geometry constants and the derived sparse
//   pipeline depth / drain length.
package mul_array_ctrl_pkg;

  // Array geometry the controller is built for.
  localparam int unsigned MUL_F          = 4;
  localparam int unsigned MUL_I          = 4;
  localparam int unsigned MUL_MAX_NUM_WT = 4;
  localparam int unsigned MUL_MAX_NUM_HT = 4;

  // Sparse pipeline index of the array; the sparse output path is one deeper.
  localparam int unsigned MUL_PIPE_N   = $clog2(MUL_MAX_NUM_WT * MUL_MAX_NUM_HT) + 2;
  localparam int unsigned MUL_L_SPARSE = MUL_PIPE_N + 1;
  localparam int unsigned MUL_L_DENSE  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mul_ctrl_state_e;

  // Cycles needed to flush the array output pipeline after the last issue.
  function automatic int unsigned drain_len(input logic sparse, input int unsigned pipe_n);
    return sparse ? (pipe_n + 1) : MUL_L_DENSE;
  endfunction

endpackage

// File: rtl/mul_array_ctrl_pair.sv
// mul_pair_counter
//   Nested (weight group, activation group) wrap counter. Inner index ia_idx
//   runs 0..last_a, outer index wt_idx steps when ia_idx wraps. Both hold
//   whenever advance is low; both wrap to 0 after the final pair.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   clear         zero both indices (tile start)
//   advance       current pair consumed this cycle
//   last_w/last_a latched group counts minus one
//   wt_idx/ia_idx current pair
//   a_last        ia_idx is the last activation group
//   last_pair     current pair is the final pair of the tile
module mul_pair_counter #(
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic [IDX_W-1:0] last_w,
  input  logic [IDX_W-1:0] last_a,
  output logic [IDX_W-1:0] wt_idx,
  output logic [IDX_W-1:0] ia_idx,
  output logic             a_last,
  output logic             last_pair
);

  assign a_last    = (ia_idx == last_a);
  assign last_pair = a_last && (wt_idx == last_w);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wt_idx <= '0;
      ia_idx <= '0;
    end else if (clear) begin
      wt_idx <= '0;
      ia_idx <= '0;
    end else if (advance) begin
      if (a_last) begin
        ia_idx <= '0;
        wt_idx <= (wt_idx == last_w) ? '0 : wt_idx + IDX_W'(1);
      end else begin
        ia_idx <= ia_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/mul_array_ctrl.sv
// mul_array_ctrl
//   Sequencing controller for the FxI multiplier array. On start it walks
//   every (weight group, activation group) pair, drives the fetch indices,
//   generates sparse/stall/partial_c for the array, waits out the array
//   output pipeline and pulses done. Crossbar backpressure (out_ready low)
//   becomes array stall.
// Optional feature: define MUL_CTRL_PERF_EN to build the issue/stall
//   performance counters; otherwise both perf ports are tied to 0.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   start                     one-cycle tile start (accepted only in IDLE)
//   sparse_mode               tile mode, latched on accepted start
//   num_w_grp/num_a_grp       group counts, latched on accepted start
//   out_ready                 crossbar accepts array output this cycle
//   wt_idx/ia_idx             pair presented to the array
//   issue_valid               pair consumed this cycle
//   sparse, stall, partial_c  array controls
//   busy, done                tile status
//   perf_issue_cnt/stall_cnt  saturating performance counters
module mul_array_ctrl
  import mul_array_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned PIPE_N = MUL_PIPE_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sparse_mode,
  input  logic [IDX_W-1:0] num_w_grp,
  input  logic [IDX_W-1:0] num_a_grp,
  input  logic             out_ready,
  output logic [IDX_W-1:0] wt_idx,
  output logic [IDX_W-1:0] ia_idx,
  output logic             issue_valid,
  output logic             sparse,
  output logic             stall,
  output logic             partial_c,
  output logic             busy,
  output logic             done,
  output logic [31:0]      perf_issue_cnt,
  output logic [31:0]      perf_stall_cnt
);

  localparam int unsigned DRAIN_W = $clog2(PIPE_N + 2);

  mul_ctrl_state_e    state_q;
  logic               sparse_q;
  logic [IDX_W-1:0]   num_w_q;
  logic [IDX_W-1:0]   num_a_q;
  logic [IDX_W-1:0]   last_w;
  logic [IDX_W-1:0]   last_a;
  logic [DRAIN_W-1:0] drain_q;
  logic               accept;
  logic               in_issue;
  logic               in_drain;
  logic               a_last;
  logic               last_pair;

  assign accept   = (state_q == ST_IDLE) && start;
  assign in_issue = (state_q == ST_ISSUE);
  assign in_drain = (state_q == ST_DRAIN);

  // Counts are never 0 while in ISSUE, so the wrap of count-1 is harmless.
  assign last_w = num_w_q - IDX_W'(1);
  assign last_a = num_a_q - IDX_W'(1);

  assign issue_valid = in_issue && out_ready;
  assign stall       = (in_issue || in_drain) && !out_ready;
  assign partial_c   = issue_valid && a_last;
  assign sparse      = sparse_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

  mul_pair_counter #(
    .IDX_W (IDX_W)
  ) u_pair (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .advance   (issue_valid),
    .last_w    (last_w),
    .last_a    (last_a),
    .wt_idx    (wt_idx),
    .ia_idx    (ia_idx),
    .a_last    (a_last),
    .last_pair (last_pair)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      sparse_q <= 1'b0;
      num_w_q  <= '0;
      num_a_q  <= '0;
      drain_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            sparse_q <= sparse_mode;
            num_w_q  <= num_w_grp;
            num_a_q  <= num_a_grp;
            state_q  <= ((num_w_grp == '0) || (num_a_grp == '0)) ? ST_DONE : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (out_ready && last_pair) begin
            drain_q <= DRAIN_W'(drain_len(sparse_q, PIPE_N));
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            drain_q <= drain_q - DRAIN_W'(1);
            if (drain_q == DRAIN_W'(1)) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MUL_CTRL_PERF_EN
  logic [31:0] perf_issue_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else if (accept) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (issue_valid && (perf_issue_q != '1)) begin
        perf_issue_q <= perf_issue_q + 32'd1;
      end
      if (stall && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_issue_cnt = perf_issue_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  assign perf_issue_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mul_array_ctrl.sv
// tb_mul_array_ctrl
//   Directed bench for mul_array_ctrl with F=I=4, max_num_Wt=max_num_Ht=4
//   (PIPE_N=6, sparse drain 7, dense drain 1).
module tb_mul_array_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sparse_mode;
  logic [7:0]  num_w_grp;
  logic [7:0]  num_a_grp;
  logic        out_ready;
  logic [7:0]  wt_idx;
  logic [7:0]  ia_idx;
  logic        issue_valid;
  logic        sparse;
  logic        stall;
  logic        partial_c;
  logic        busy;
  logic        done;
  logic [31:0] perf_issue_cnt;
  logic [31:0] perf_stall_cnt;

  int unsigned tests_run;
  int unsigned tests_failed;

  mul_array_ctrl #(
    .IDX_W  (8),
    .PIPE_N (6)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .sparse_mode    (sparse_mode),
    .num_w_grp      (num_w_grp),
    .num_a_grp      (num_a_grp),
    .out_ready      (out_ready),
    .wt_idx         (wt_idx),
    .ia_idx         (ia_idx),
    .issue_valid    (issue_valid),
    .sparse         (sparse),
    .stall          (stall),
    .partial_c      (partial_c),
    .busy           (busy),
    .done           (done),
    .perf_issue_cnt (perf_issue_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic exp_sparse);
    check({tag, " wt_idx"},      32'(wt_idx),      32'd0);
    check({tag, " ia_idx"},      32'(ia_idx),      32'd0);
    check({tag, " issue_valid"}, 32'(issue_valid), 32'd0);
    check({tag, " stall"},       32'(stall),       32'd0);
    check({tag, " partial_c"},   32'(partial_c),   32'd0);
    check({tag, " busy"},        32'(busy),        32'd0);
    check({tag, " done"},        32'(done),        32'd0);
    check({tag, " sparse"},      32'(sparse),      32'(exp_sparse));
  endtask

  // Runs one tile. Cycle t is the cycle in which start is high; k counts
  // cycles after t. low_mask bit k drops out_ready in cycle t+k. ghost_at
  // pulses a second start with different settings; abort_at asserts reset.
  task automatic run_tile(input string tag, input logic sp, input int w, input int a,
                          input logic [31:0] low_mask, input int done_at,
                          input int exp_stalls, input int exp_issues,
                          input int ghost_at, input int abort_at);
    int   issued;
    int   dr;
    int   total;
    int   n_done;
    int   n_stall;
    int   n_iv;
    logic empty;
    logic rdy;
    logic in_iss;
    logic in_drn;
    string ct;

    start       = 1'b1;
    sparse_mode = sp;
    num_w_grp   = 8'(w);
    num_a_grp   = 8'(a);
    out_ready   = 1'b1;
    issued  = 0;
    dr      = sp ? 7 : 1;
    total   = w * a;
    empty   = (w == 0) || (a == 0);
    n_done  = 0;
    n_stall = 0;
    n_iv    = 0;

    for (int k = 1; k <= done_at + 1; k++) begin
      @(posedge clk);
      @(negedge clk);
      start     = 1'b0;
      rdy       = !low_mask[k];
      out_ready = rdy;
      ct = $sformatf("%s k=%0d", tag, k);
      if (k == ghost_at) begin
        start       = 1'b1;
        num_w_grp   = 8'd1;
        num_a_grp   = 8'd1;
        sparse_mode = !sp;
      end
      if (k == abort_at) begin
        rst = 1'b0;
        #1;
        check_idle_outputs({ct, " abort"}, 1'b0);
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check($sformatf("%s post-abort%0d done", tag, j), 32'(done), 32'd0);
          check($sformatf("%s post-abort%0d busy", tag, j), 32'(busy), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        return;
      end
      #1;
      in_iss = !empty && (issued < total);
      in_drn = !empty && !in_iss && (dr > 0);

      check({ct, " issue_valid"}, 32'(issue_valid), 32'(in_iss && rdy));
      check({ct, " stall"},       32'(stall),       32'((in_iss || in_drn) && !rdy));
      check({ct, " done"},        32'(done),        32'(k == done_at));
      check({ct, " busy"},        32'(busy),        32'(k <= done_at));
      check({ct, " sparse"},      32'(sparse),      32'(sp));
      if (in_iss) begin
        check({ct, " wt_idx"},    32'(wt_idx),    32'(issued / a));
        check({ct, " ia_idx"},    32'(ia_idx),    32'(issued % a));
        check({ct, " partial_c"}, 32'(partial_c), 32'(rdy && ((issued % a) == a - 1)));
      end else begin
        check({ct, " partial_c"}, 32'(partial_c), 32'd0);
      end

      n_done  += int'(done);
      n_stall += int'(stall);
      n_iv    += int'(issue_valid);
      if (in_iss && rdy) issued++;
      if (in_drn && rdy) dr--;
    end

    check({tag, " done pulses"},  32'(n_done),  32'd1);
    check({tag, " stall cycles"}, 32'(n_stall), 32'(exp_stalls));
    check({tag, " issue cycles"}, 32'(n_iv),    32'(exp_issues));
    check_idle_outputs({tag, " idle"}, sp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst         = 1'b0;
    start       = 1'b0;
    sparse_mode = 1'b0;
    num_w_grp   = '0;
    num_a_grp   = '0;
    out_ready   = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("reset", 1'b0);
    check("reset perf_issue", perf_issue_cnt, 32'd0);
    check("reset perf_stall", perf_stall_cnt, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Sparse W=2 A=3: 6 issues, done at t+1+6+7.
    run_tile("sp2x3", 1'b1, 2, 3, 32'h0, 14, 0, 6, 0, 0);

    // Dense W=3 A=1: partial_c on every issue, done at t+5.
    run_tile("dn3x1", 1'b0, 3, 1, 32'h0, 5, 0, 3, 0, 0);

    // Sparse W=1 A=4, out_ready low in cycles t+3, t+4 (ISSUE) and t+9 (DRAIN).
    run_tile("sp1x4stall", 1'b1, 1, 4, 32'h0000_0218, 15, 3, 4, 0, 0);
`ifdef MUL_CTRL_PERF_EN
    check("sp1x4stall perf_stall", perf_stall_cnt, 32'd3);
    check("sp1x4stall perf_issue", perf_issue_cnt, 32'd4);
`else
    check("sp1x4stall perf_stall", perf_stall_cnt, 32'd0);
    check("sp1x4stall perf_issue", perf_issue_cnt, 32'd0);
`endif

    // Empty tile: done one cycle after start, nothing issued.
    run_tile("empty0x5", 1'b1, 0, 5, 32'h0, 1, 0, 0, 0, 0);

    // Reset during DRAIN of sparse W=2 A=2 (DRAIN spans t+5..t+11).
    run_tile("abort2x2", 1'b1, 2, 2, 32'h0, 12, 0, 4, 0, 7);
    check("abort perf_issue", perf_issue_cnt, 32'd0);
    check("abort perf_stall", perf_stall_cnt, 32'd0);
    run_tile("after_abort2x2", 1'b1, 2, 2, 32'h0, 12, 0, 4, 0, 0);

    // Start pulsed in ISSUE with other counts/mode is ignored.
    run_tile("ghost2x3", 1'b1, 2, 3, 32'h0, 14, 0, 6, 2, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mul_array_ctrl.md
# mul_array_ctrl

Sequencing controller for the F×I multiplier array. On `start` it walks every (weight group, activation group) pair of a tile, drives the fetch indices to the weight and IARAM readers, and generates the array's `sparse`, `stall` and `Partial_c` controls. It then waits out the array's output pipeline (sparse depth N+1, dense depth 1) before pulsing `done`. It sits between the PE tile sequencer and `Multiplier_Array`; downstream crossbar backpressure is converted into the array `stall`.

## Interface
Parameters:
- `IDX_W`, 8: width of group counts and indices.
- `PIPE_N`, `$clog2(max_num_Wt*max_num_Ht)+2`: array sparse pipeline index; sparse drain latency is PIPE_N+1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle tile start; ignored unless IDLE.
- `sparse_mode`  in  1  mode for the tile; latched on accepted `start`.
- `num_w_grp`  in  IDX_W  number of weight groups; latched on `start`; 0 means empty.
- `num_a_grp`  in  IDX_W  number of activation groups; latched on `start`; 0 means empty.
- `out_ready`  in  1  crossbar can accept array output this cycle.
- `wt_idx`  out  IDX_W  weight group to present to the array.
- `ia_idx`  out  IDX_W  activation group to present to the array.
- `issue_valid`  out  1  pair at `wt_idx`/`ia_idx` is consumed this cycle.
- `sparse`  out  1  latched mode, to the array.
- `stall`  out  1  array stall.
- `partial_c`  out  1  to array `Partial_c`; marks the last activation group of the current weight group.
- `busy`  out  1  high from accepted `start` through the `done` cycle.
- `done`  out  1  one-cycle tile-complete pulse.
- `perf_issue_cnt`, `perf_stall_cnt`  out  32 each  performance counters (see Configuration).

## Operation
- FSM states: IDLE → ISSUE → DRAIN → DONE → IDLE.
- IDLE:
  - All outputs are 0 except `sparse`, which holds its last latched value.
  - On `start`, latch mode and counts and clear both indices.
  - If either count is 0, go to DONE. Otherwise go to ISSUE.
- ISSUE:
  - Loop order: outer `wt_idx`, inner `ia_idx`.
  - Advance only when `out_ready`=1. `ia_idx` wraps to 0 after `num_a_grp-1` and `wt_idx` then increments.
  - `partial_c` = ISSUE & `out_ready` & (`ia_idx`==`num_a_grp-1`).
  - When the final pair (`num_w_grp-1`, `num_a_grp-1`) issues, load the drain counter with L = `sparse` ? PIPE_N+1 : 1 and go to DRAIN.
- DRAIN:
  - The counter decrements only when `out_ready`=1.
  - Go to DONE when a decrement takes it from 1 to 0.
- DONE: `done`=1 for one cycle, then IDLE.
- `issue_valid` = ISSUE & `out_ready`.
- `stall` = (ISSUE | DRAIN) & ~`out_ready`. Indices and the drain counter hold while `stall`=1.
- `start` outside IDLE is ignored. Count inputs are sampled only at accepted `start`.
- Asynchronous reset at any point:
  - State goes to IDLE; indices, drain counter and perf counters clear; `sparse` goes to 0.
  - No `done` is produced for the aborted tile.
- Width rule: internal comparisons use latched count minus 1 in IDX_W bits. Counts are never 0 in ISSUE.

## Timing
- `start` at cycle t with non-zero counts:
  - ISSUE begins at t+1.
  - With no stall, `issue_valid` is high for W·A consecutive cycles (W=`num_w_grp`, A=`num_a_grp`).
  - DRAIN lasts L cycles.
  - `done` is asserted at t+1+W·A+L.
- Each stall cycle adds exactly one cycle to this timeline.
- Empty tile (either count 0): `done` at t+1, with no `issue_valid` and no `stall`.
- `busy` rises at t+1 and falls after the `done` cycle.
- All state and index outputs are driven from flops. `issue_valid`, `stall` and `partial_c` are combinational in `out_ready`.

## Configuration
- `MUL_CTRL_PERF_EN` defined:
  - `perf_issue_cnt` increments on each `issue_valid` cycle.
  - `perf_stall_cnt` increments on each `stall` cycle.
  - Both clear on accepted `start` and on reset, and saturate at all-ones.
- `MUL_CTRL_PERF_EN` not defined: both counters are removed and the ports are tied to 0.

## Structure
- Shared package holds:
  - the FSM state enum `mul_ctrl_state_e` (IDLE, ISSUE, DRAIN, DONE);
  - the PIPE_N/L constants derived from `max_num_Wt`, `max_num_Ht`, `F`, `I`.
- One sub-module: `mul_pair_counter`, the nested wrap counter with hold-on-stall that produces `wt_idx`, `ia_idx` and the last-pair flag.
- The FSM, drain counter and perf logic stay in the top module.

## Test plan
Configuration for all scenarios: F=I=4, max_num_Wt=max_num_Ht=4, so PIPE_N=6 and sparse L=7.
- Sparse tile, W=2, A=3, `out_ready`=1 → 6 `issue_valid` cycles with pairs (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); `partial_c` on (0,2) and (1,2); `done` at t+14.
- Dense tile, W=3, A=1 → `partial_c` on every issue; L=1; `done` at t+5.
- Sparse tile, W=1, A=4, `out_ready` low for 2 cycles mid-ISSUE and 1 cycle in DRAIN → `stall` high for exactly 3 cycles; indices hold during the stall; `done` at t+15; `perf_stall_cnt`=3 with `MUL_CTRL_PERF_EN`.
- W=0, A=5 → `done` at t+1, no `issue_valid`, `busy` high for 1 cycle.
- `rst` asserted during DRAIN of W=2, A=2 → immediate return to IDLE, all outputs 0, no `done`. A new `start` afterwards completes normally.
- `start` pulsed while in ISSUE with different counts → ignored; the original tile's pair sequence and `done` timing are unchanged.
